// File: rtl/div_sequencer_pkg.sv
// Shared defines for the divider sequencer: FSM encodings, iteration count and ALU control codes.
package div_sequencer_pkg;

  localparam int DIV_WIDTH  = 32;
  localparam int DIV_CYCLES = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_DIV  = 4'd7,
    ALU_DIVU = 4'd8
  } alu_ctrl_e;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, and shift out one quotient bit.
module div_step
  import div_sequencer_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] part;
  logic [WIDTH:0] diff;
  logic           fits;

  always_comb begin
    part  = {rem_i, quo_i[WIDTH-1]};
    diff  = part - {1'b0, dvs_i};
    // No borrow means the divisor fits; the partial remainder stays below the divisor.
    fits  = ~diff[WIDTH];
    rem_o = fits ? diff[WIDTH-1:0] : part[WIDTH-1:0];
    quo_o = {quo_i[WIDTH-2:0], fits};
  end

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV/DIVU: valid DIV_CYCLES+1 cycles after start (1 cycle for a zero divisor).
// Holds the pipeline via stall while accepting/busy; annul abandons the operation with no valid.
module div_sequencer #(
  parameter int WIDTH      = div_sequencer_pkg::DIV_WIDTH,
  parameter int DIV_CYCLES = div_sequencer_pkg::DIV_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_div,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic             annul,
  output logic             stall,
  output logic             valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  import div_sequencer_pkg::*;

  localparam int            CW        = $clog2(DIV_CYCLES + 1);
  localparam logic [CW-1:0] LAST_STEP = CW'(DIV_CYCLES - 1);

  if (DIV_CYCLES != WIDTH) begin : g_cfg_err
    $error("div_sequencer: DIV_CYCLES must equal WIDTH");
  end

  div_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic [WIDTH-1:0] rem_nx, quo_nx;
  logic [WIDTH-1:0] abs_a, abs_b;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .dvs_i (dvs_q),
    .rem_o (rem_nx),
    .quo_o (quo_nx)
  );

  always_comb begin
    abs_a = (signed_div && opa[WIDTH-1]) ? -opa : opa;
    abs_b = (signed_div && opb[WIDTH-1]) ? -opb : opb;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    valid_d = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;

    if (annul) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            rem_d  = '0;
            quo_d  = abs_a;
            dvs_d  = abs_b;
            qneg_d = signed_div & (opa[WIDTH-1] ^ opb[WIDTH-1]);
            rneg_d = signed_div & opa[WIDTH-1];
            cnt_d  = '0;
            if (opb == '0) begin
              state_d = ST_DONE;
              valid_d = 1'b1;
              lo_d    = '1;
              hi_d    = opa;
            end else begin
              state_d = ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          rem_d = rem_nx;
          quo_d = quo_nx;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST_STEP) begin
            state_d = ST_DONE;
            valid_d = 1'b1;
            // Quotient truncates toward zero; remainder follows the dividend's sign.
            lo_d    = qneg_q ? -quo_nx : quo_nx;
            hi_d    = rneg_q ? -rem_nx : rem_nx;
          end
        end
        ST_DONE: state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      valid_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      valid_q <= valid_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign stall = ((state_q == ST_IDLE) && start && !annul) || (state_q == ST_BUSY);
  assign valid = valid_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: latency, stall window, signed fix-up, divide by zero,
// annul, ignored start and reset during an operation.
module tb_div_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        signed_div;
  logic [31:0] opa;
  logic [31:0] opb;
  logic        annul;
  logic        stall;
  logic        valid;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  div_sequencer #(.WIDTH(32), .DIV_CYCLES(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .signed_div (signed_div),
    .opa        (opa),
    .opb        (opb),
    .annul      (annul),
    .stall      (stall),
    .valid      (valid),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  // Drive a start during "cycle 0"; returns #1 after the inputs settle.
  task automatic issue(input logic s, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    signed_div = s;
    opa        = a;
    opb        = b;
    start      = 1'b1;
    annul      = 1'b0;
    #1;
  endtask

  // Observe cycles 1..n after an issue; operands are scrambled so only latched values matter.
  task automatic watch(input int n, input int annul_at, input int restart_at,
                       output int vcyc, output int vcnt, output int stall_last,
                       output int stall_first_low, output logic [31:0] vlo,
                       output logic [31:0] vhi);
    vcyc = -1; vcnt = 0; stall_last = -1; stall_first_low = -1; vlo = '0; vhi = '0;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      if (k == 1) begin
        opa = 32'hDEAD_BEEF;
        opb = 32'h0000_0003;
      end
      start = (k == restart_at);
      annul = (k == annul_at);
      #1;
      if (valid) begin
        if (vcyc < 0) vcyc = k;
        vcnt++;
        vlo = lo;
        vhi = hi;
      end
      if (stall) stall_last = k;
      else if (stall_first_low < 0) stall_first_low = k;
    end
    start = 1'b0;
    annul = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; opa = '0; opb = '0;
    #12;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", valid); end
    total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi got=%h want=0", hi); end
    total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo got=%h want=0", lo); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b want=0", stall); end
    start = 1'b1;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL reset_stall_start got=%b want=1", stall); end
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_unsigned_basic;
    int vc, vn, sl, sf;
    logic [31:0] vl, vh;
    issue(1'b0, 32'd100, 32'd7);
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL u100_stall_c0 got=%b want=1", stall); end
    watch(40, 0, 0, vc, vn, sl, sf, vl, vh);
    total++; if (vc !== 33) begin bad++; $display("FAIL u100_valid_cycle got=%0d want=33", vc); end
    total++; if (vn !== 1) begin bad++; $display("FAIL u100_valid_count got=%0d want=1", vn); end
    total++; if (sl !== 32) begin bad++; $display("FAIL u100_stall_last got=%0d want=32", sl); end
    total++; if (sf !== 33) begin bad++; $display("FAIL u100_stall_first_low got=%0d want=33", sf); end
    total++; if (vl !== 32'd14) begin bad++; $display("FAIL u100_lo got=%h want=%h", vl, 32'd14); end
    total++; if (vh !== 32'd2) begin bad++; $display("FAIL u100_hi got=%h want=%h", vh, 32'd2); end
    total++; if (lo !== 32'd14 || hi !== 32'd2) begin
      bad++; $display("FAIL u100_hold got lo=%h hi=%h want lo=%h hi=%h", lo, hi, 32'd14, 32'd2);
    end
  endtask

  task automatic test_signed;
    logic        s_t[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] a_t[4]  = '{32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFF9, 32'h0000_0007};
    logic [31:0] b_t[4]  = '{32'h0000_0002, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE};
    logic [31:0] ql_t[4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'h7FFF_FFFC, 32'hFFFF_FFFD};
    logic [31:0] qh_t[4] = '{32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 32'h0000_0001};
    int vc, vn, sl, sf;
    logic [31:0] vl, vh;
    for (int i = 0; i < 4; i++) begin
      issue(s_t[i], a_t[i], b_t[i]);
      watch(36, 0, 0, vc, vn, sl, sf, vl, vh);
      total++; if (vc !== 33) begin bad++; $display("FAIL sgn%0d_valid_cycle got=%0d want=33", i, vc); end
      total++; if (vl !== ql_t[i]) begin bad++; $display("FAIL sgn%0d_lo got=%h want=%h", i, vl, ql_t[i]); end
      total++; if (vh !== qh_t[i]) begin bad++; $display("FAIL sgn%0d_hi got=%h want=%h", i, vh, qh_t[i]); end
    end
  endtask

  task automatic test_div_zero;
    logic        s_t[2] = '{1'b0, 1'b1};
    logic [31:0] a_t[2] = '{32'd5, 32'hFFFF_FFF9};
    int vc, vn, sl, sf;
    logic [31:0] vl, vh;
    for (int i = 0; i < 2; i++) begin
      issue(s_t[i], a_t[i], 32'h0);
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL dz%0d_stall_c0 got=%b want=1", i, stall); end
      watch(5, 0, 0, vc, vn, sl, sf, vl, vh);
      total++; if (vc !== 1) begin bad++; $display("FAIL dz%0d_valid_cycle got=%0d want=1", i, vc); end
      total++; if (vn !== 1) begin bad++; $display("FAIL dz%0d_valid_count got=%0d want=1", i, vn); end
      total++; if (sf !== 1) begin bad++; $display("FAIL dz%0d_stall_first_low got=%0d want=1", i, sf); end
      total++; if (vl !== 32'hFFFF_FFFF) begin bad++; $display("FAIL dz%0d_lo got=%h want=ffffffff", i, vl); end
      total++; if (vh !== a_t[i]) begin bad++; $display("FAIL dz%0d_hi got=%h want=%h", i, vh, a_t[i]); end
    end
  endtask

  task automatic test_annul;
    int vc, vn, sl, sf;
    logic [31:0] vl, vh;
    issue(1'b0, 32'd100, 32'd7);
    watch(40, 10, 0, vc, vn, sl, sf, vl, vh);
    total++; if (vn !== 0) begin bad++; $display("FAIL annul_no_valid got=%0d want=0", vn); end
    total++; if (sf !== 11) begin bad++; $display("FAIL annul_idle_cycle got=%0d want=11", sf); end
    total++; if (lo !== 32'hFFFF_FFFF || hi !== 32'hFFFF_FFF9) begin
      bad++; $display("FAIL annul_hold got lo=%h hi=%h want lo=ffffffff hi=fffffff9", lo, hi);
    end
    issue(1'b0, 32'd12, 32'd4);
    watch(40, 0, 0, vc, vn, sl, sf, vl, vh);
    total++; if (vc !== 33) begin bad++; $display("FAIL annul_next_valid_cycle got=%0d want=33", vc); end
    total++; if (vl !== 32'd3) begin bad++; $display("FAIL annul_next_lo got=%h want=3", vl); end
    total++; if (vh !== 32'd0) begin bad++; $display("FAIL annul_next_hi got=%h want=0", vh); end
  endtask

  task automatic test_annul_priority;
    int vc, vn, sl, sf;
    logic [31:0] vl, vh;
    @(negedge clk);
    signed_div = 1'b0; opa = 32'd9; opb = 32'd0; start = 1'b1; annul = 1'b1;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL prio_stall got=%b want=0", stall); end
    watch(5, 0, 0, vc, vn, sl, sf, vl, vh);
    total++; if (vn !== 0) begin bad++; $display("FAIL prio_no_valid got=%0d want=0", vn); end
  endtask

  task automatic test_start_ignored;
    int vc, vn, sl, sf;
    logic [31:0] vl, vh;
    issue(1'b0, 32'd100, 32'd7);
    watch(80, 0, 5, vc, vn, sl, sf, vl, vh);
    total++; if (vn !== 1) begin bad++; $display("FAIL busy_start_valid_count got=%0d want=1", vn); end
    total++; if (vc !== 33) begin bad++; $display("FAIL busy_start_valid_cycle got=%0d want=33", vc); end
    total++; if (vl !== 32'd14) begin bad++; $display("FAIL busy_start_lo got=%h want=%h", vl, 32'd14); end
  endtask

  task automatic test_rst_busy;
    int vc, vn, sl, sf;
    logic [31:0] vl, vh;
    issue(1'b0, 32'd100, 32'd7);
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 5) rst = 1'b1;
    end
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rstbusy_stall got=%b want=0", stall); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL rstbusy_valid got=%b want=0", valid); end
    total++; if (lo !== 32'h0 || hi !== 32'h0) begin
      bad++; $display("FAIL rstbusy_outputs got lo=%h hi=%h want 0", lo, hi);
    end
    @(negedge clk);
    rst = 1'b0;
    watch(40, 0, 0, vc, vn, sl, sf, vl, vh);
    total++; if (vn !== 0) begin bad++; $display("FAIL rstbusy_no_valid got=%0d want=0", vn); end
    total++; if (sl !== -1) begin bad++; $display("FAIL rstbusy_stall_after got=%0d want=-1", sl); end
  endtask

  initial begin
    test_reset;
    test_unsigned_basic;
    test_signed;
    test_div_zero;
    test_annul;
    test_annul_priority;
    test_start_ignored;
    test_rst_busy;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand and result width in bits.
REQ-002 SHALL have parameter DIV_CYCLES, default 32, meaning the number of iteration cycles; it SHALL equal WIDTH.
REQ-003 SHALL have port clk  input  1  the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port start  input  1  request a divide; sampled only in IDLE.
REQ-006 SHALL have port signed_div  input  1  1 = DIV (signed), 0 = DIVU; sampled with start.
REQ-007 SHALL have port opa  input  WIDTH  dividend; sampled with start.
REQ-008 SHALL have port opb  input  WIDTH  divisor; sampled with start.
REQ-009 SHALL have port annul  input  1  pipeline flush; abandons the current operation.
REQ-010 SHALL have port stall  output  1  freeze request to the pipeline.
REQ-011 SHALL have port valid  output  1  one-cycle strobe: hi and lo are valid for HI/LO write.
REQ-012 SHALL have port hi  output  WIDTH  remainder.
REQ-013 SHALL have port lo  output  WIDTH  quotient.

Function
REQ-014 SHALL implement an FSM with states IDLE, BUSY, DONE.
REQ-015 IDLE with start=1 and annul=0 SHALL latch operands and signedness, clear the iteration counter, and go to BUSY; if opb==0, it SHALL go to DONE instead.
REQ-016 In BUSY, each cycle SHALL perform one restoring-division step on the absolute values and increment the counter; after step DIV_CYCLES-1, the FSM SHALL go to DONE.
REQ-017 DONE SHALL assert valid for exactly one cycle and return to IDLE unconditionally.
REQ-018 A start sampled at cycle 0 SHALL give valid at cycle DIV_CYCLES+1 (33 for the defaults); a zero divisor SHALL give valid at cycle 1.
REQ-019 stall SHALL be combinational and equal (IDLE & start & ~annul) | BUSY; it SHALL be low in DONE.
REQ-020 For a signed divide, the quotient SHALL be negated when the operand signs differ, and the remainder SHALL take the sign of the dividend.
REQ-021 The case 0x80000000 / 0xFFFFFFFF (signed) SHALL give lo=0x80000000 and hi=0; the result wraps in two's complement.
REQ-022 A divide by zero SHALL give lo=all-ones and hi=opa.
REQ-023 annul=1 in any state SHALL force IDLE on the next edge, and valid SHALL NOT be asserted for the abandoned operation.
REQ-024 annul has priority over start when both are asserted in the same cycle.
REQ-025 start asserted in BUSY or DONE SHALL be ignored; it is not queued.
REQ-026 hi and lo SHALL hold their last values until the next DONE.

Reset
REQ-027 rst SHALL asynchronously force the state to IDLE, the counter to 0, and valid, hi, lo and internal registers to 0; stall SHALL be 0 unless start is asserted.
REQ-028 A reset during BUSY SHALL discard the operation without a valid pulse.

Structure
REQ-029 State encodings and DIV_CYCLES SHALL live in the shared defines header alongside the ALU control codes.
REQ-030 A single sub-module div_step SHALL hold one combinational restoring step: shift-subtract producing the next remainder and quotient bit. div_sequencer SHALL own the FSM, counter, sign fix-up and output registers.

Verification
REQ-031 Unsigned 100 / 7, start at cycle 0 -> stall high in cycles 0-32, valid at cycle 33, lo=14, hi=2.
REQ-032 Signed 0xFFFFFFF9 (-7) / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-033 Signed 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-034 opa=5, opb=0 -> valid at cycle 1, lo=0xFFFFFFFF, hi=5.
REQ-035 annul at cycle 10 of BUSY, then a new start 12/4 -> no valid for the first op; second op lo=3, hi=0, valid 33 cycles after its start.
REQ-036 rst pulsed at cycle 5 of BUSY -> immediately IDLE, outputs 0, no valid pulse; start during BUSY -> ignored, with a single valid.
